neuron_mac_sequencer: RTL and testbench
=======================================

// Module: neuron_mac_sequencer
// PURPOSE
//  Consumer stage placed directly after one neuron's weight BRAM and its activation buffer.
//  After START it sweeps ADDR 0..N_IN-1 and drives that one address to both memories.
//  Each returned weight/activation pair is multiplied and accumulated; BIAS is then added.
//  The sum is rescaled, saturated and optionally ReLU'd, and the result is held on a
//  valid/ready output to the next layer.
// PARAMETERS
//  N_IN     28   inputs per neuron = BRAM depth
//  ADDR_W   5    address width
//  DATA_W   16   weight/activation/output width, signed two's complement
//  FRAC     8    fractional bits of the Q8.8 format
//  ACC_W    40   accumulator width
//  RELU_EN  1    1: clamp negative results to 0 at the output
// PORTS
//  CLK        in   1       clock; all logic here is posedge
//  RST_N      in   1       asynchronous, active-low reset
//  START      in   1       request one neuron evaluation; sampled in IDLE only
//  BIAS       in   DATA_W  Q8.8 bias, captured on the cycle START is accepted
//  BUSY       out  1       high in every state except IDLE
//  ADDR       out  ADDR_W  shared read address to the weight BRAM and the activation BRAM
//  EN         out  1       read enable to both memories
//  WE         out  1       tied 0; this block never writes
//  W_DO       in   DATA_W  weight read data; memories read on negedge, valid at the next posedge
//  X_DO       in   DATA_W  activation read data; same timing as W_DO
//  OUT_DATA   out  DATA_W  Q8.8 neuron result
//  OUT_VALID  out  1       OUT_DATA valid; held until the handshake completes
//  OUT_READY  in   1       downstream accept
// BEHAVIOUR
//  Reset: state=IDLE; ADDR=0; EN=0; BUSY=0; OUT_VALID=0; OUT_DATA=0; accumulator and pipe flag=0.
//  Reset taking effect mid-operation aborts the evaluation immediately. The partial sum is discarded.
//  FSM states and transitions:
//   IDLE  -> RUN   on START; capture BIAS; clear the accumulator.
//   RUN   : EN=1; ADDR steps 0,1,..,N_IN-1, one address per cycle.
//           Go to DRAIN after issuing N_IN-1.
//   DRAIN : EN=0; absorb the last read-data beat.
//   FINAL : compute sum = acc + (BIAS <<< FRAC);
//           res = sum >>> FRAC (arithmetic shift, floor, no rounding);
//           saturate res to [0x8000, 0x7FFF]; if RELU_EN and res<0 then res=0;
//           register res into OUT_DATA; set OUT_VALID.
//   DONE  : hold OUT_DATA and OUT_VALID stable.
//           OUT_VALID && OUT_READY -> IDLE next cycle; OUT_VALID drops.
//  Data pipe: rd_vld = EN delayed by one cycle.
//   When rd_vld is high: acc += sext(W_DO) * sext(X_DO), a 32-bit signed product.
//  Timing: START accepted at cycle 0 -> ADDR 0 issued at cycle 1 -> OUT_VALID first high at cycle N_IN+3 (31).
//  Accumulator cannot overflow: 28 x 2^30 < 2^39.
//  ADDR never exceeds N_IN-1, so there is no wrap. ADDR returns to 0 when the block leaves RUN.
//  START is ignored whenever BUSY=1.
//   After a handshake there is at least one IDLE cycle before the next START is accepted.
//  OUT_READY outside DONE: ignored.
// STRUCTURE
//  ann_pkg: DATA_W, FRAC, ACC_W, state enum, function sat16(acc) -> DATA_W.
//  One sub-module, neuron_mac_dp: multiplier, accumulator, bias/shift/saturate/ReLU.
//   Its inputs are clr, acc_en, fin_en.
//  The top level of this block keeps the FSM and the address counter.
// TESTING
//  1. All W=0x0100, all X=0x0100, BIAS=0 -> OUT_DATA=0x1C00 (28.0).
//     OUT_VALID rises exactly 31 cycles after START.
//  2. All W=0xFF00, all X=0x0080, BIAS=0:
//     RELU_EN=1 -> OUT_DATA=0x0000; RELU_EN=0 -> OUT_DATA=0xF200 (-14.0).
//  3. All W=0x7FFF, all X=0x7FFF -> OUT_DATA=0x7FFF.
//     Same with X=0x8001 and RELU_EN=0 -> OUT_DATA=0x8000.
//  4. All W=0, BIAS=0x0380 -> OUT_DATA=0x0380.
//     Hold OUT_READY=0 for 10 cycles and pulse START during that time
//     -> OUT_DATA/OUT_VALID stable, BUSY=1, START ignored; ready=1 -> IDLE next cycle.
//  5. Assert RST_N=0 while ADDR=10 in RUN -> EN=0, ADDR=0, OUT_VALID=0 immediately (asynchronous).
//     Rerun test 1 -> OUT_DATA=0x1C00.
//  6. Check every EN-high cycle: ADDR sequence is 0..27 with no gaps; EN high for exactly 28 cycles; WE=0 throughout.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared widths, FSM state encoding and the output saturation helper for the
// neuron MAC sequencer and its datapath.
package ann_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int ACC_W  = 40;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINAL,
        ST_DONE
    } state_e;

    // Clamp a wide signed value into the Q8.8 range [0x8000, 0x7FFF].
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        if (top == '0 || top == '1) begin
            return v[DATA_W-1:0];
        end else if (v[ACC_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/neuron_mac_dp.sv
// Datapath for one neuron: registered multiplier, 40-bit accumulator and the
// bias / rescale / saturate / ReLU output stage.
module neuron_mac_dp
    import ann_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     acc_en_i,
    input  logic                     fin_en_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] out_data_o
);

    logic signed [PROD_W-1:0] prod_q;
    logic                     rd_vld_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [DATA_W-1:0] out_q;

    logic signed [PROD_W-1:0] prod_d;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  res;
    logic signed [DATA_W-1:0] res_d;

    assign prod_d   = w_i * x_i;
    assign prod_ext = $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
    assign bias_ext = $signed({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q});

    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        sum   = acc_q + (bias_ext <<< FRAC);
        res   = sum >>> FRAC;
        res_d = sat16(res);
        if (RELU_EN && res_d[DATA_W-1]) begin
            res_d = '0;
        end
    end

    // The product is registered on the beat the memories return data; it is
    // folded into the accumulator one cycle later, qualified by rd_vld_q.
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q   <= '0;
            rd_vld_q <= 1'b0;
            acc_q    <= '0;
            bias_q   <= '0;
            out_q    <= '0;
        end else begin
            if (clr_i) begin
                rd_vld_q <= 1'b0;
                acc_q    <= '0;
                bias_q   <= bias_i;
            end else begin
                rd_vld_q <= acc_en_i;
                if (acc_en_i) begin
                    prod_q <= prod_d;
                end
                if (rd_vld_q) begin
                    acc_q <= acc_q + prod_ext;
                end
            end
            if (fin_en_i) begin
                out_q <= res_d;
            end
        end
    end

    assign out_data_o = out_q;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sweeps one neuron's weight and activation memories, accumulates the dot
// product through neuron_mac_dp and presents the result on a valid/ready port.
module neuron_mac_sequencer
    import ann_pkg::*;
#(
    parameter int N_IN    = 28,
    parameter int ADDR_W  = 5,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic                     busy_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic                     en_o,
    output logic                     we_o,
    input  logic signed [DATA_W-1:0] w_do_i,
    input  logic signed [DATA_W-1:0] x_do_i,
    output logic signed [DATA_W-1:0] out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              en_q;
    logic              busy_q;
    logic              valid_q;

    logic clr;
    logic fin_en;

    assign clr    = (state_q == ST_IDLE) && start_i;
    assign fin_en = (state_q == ST_FINAL);

    // NOTE: the async reset covers only control and datapath registers; there is no memory array here to reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        addr_q  <= '0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= ST_DRAIN;
                        addr_q  <= '0;
                        en_q    <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_q <= ST_DONE;
                    valid_q <= 1'b1;
                end
                ST_DONE: begin
                    // Result stays put until the next layer takes it.
                    if (out_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    neuron_mac_dp #(
        .RELU_EN (RELU_EN)
    ) u_dp (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr),
        .acc_en_i   (en_q),
        .fin_en_i   (fin_en),
        .bias_i     (bias_i),
        .w_i        (w_do_i),
        .x_i        (x_do_i),
        .out_data_o (out_data_o)
    );

    assign busy_o      = busy_q;
    assign addr_o      = addr_q;
    assign en_o        = en_q;
    assign we_o        = 1'b0;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench: two sequencers (ReLU on and off) share stimulus and the same
// memory contents; results are compared against hand-computed Q8.8 values.
module tb_neuron_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] bias = '0;

    logic [15:0] w_mem [0:31];
    logic [15:0] x_mem [0:31];

    logic        busy_r, en_r, we_r, valid_r;
    logic [4:0]  addr_r;
    logic [15:0] w_do_r = '0, x_do_r = '0, data_r;
    logic        busy_l, en_l, we_l, valid_l;
    logic [4:0]  addr_l;
    logic [15:0] w_do_l = '0, x_do_l = '0, data_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_mac_sequencer #(.N_IN(28), .ADDR_W(5), .RELU_EN(1'b1)) u_relu (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
        .busy_o(busy_r), .addr_o(addr_r), .en_o(en_r), .we_o(we_r),
        .w_do_i(w_do_r), .x_do_i(x_do_r),
        .out_data_o(data_r), .out_valid_o(valid_r), .out_ready_i(out_ready)
    );

    neuron_mac_sequencer #(.N_IN(28), .ADDR_W(5), .RELU_EN(1'b0)) u_lin (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
        .busy_o(busy_l), .addr_o(addr_l), .en_o(en_l), .we_o(we_l),
        .w_do_i(w_do_l), .x_do_i(x_do_l),
        .out_data_o(data_l), .out_valid_o(valid_l), .out_ready_i(out_ready)
    );

    // Memory models: read on negedge while enabled, data valid at the next posedge.
    always @(negedge clk) begin
        if (en_r) begin
            w_do_r <= w_mem[addr_r];
            x_do_r <= x_mem[addr_r];
        end
        if (en_l) begin
            w_do_l <= w_mem[addr_l];
            x_do_l <= x_mem[addr_l];
        end
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 32; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    // One evaluation: START, bounded wait for OUT_VALID while watching the
    // address sweep, result checks, then an optional handshake.
    task automatic run_eval(input string tag, input logic [15:0] bias_v,
                            input logic [15:0] exp_r, input logic [15:0] exp_l,
                            input bit do_handshake);
        int cyc;
        int en_cnt;
        int exp_addr;
        bit addr_ok;
        bit we_ok;
        cyc = 0;
        en_cnt = 0;
        exp_addr = 0;
        addr_ok = 1'b1;
        we_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        bias = bias_v;
        while (cyc < 100 && !valid_r) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (en_r) begin
                if (addr_r !== exp_addr[4:0]) addr_ok = 1'b0;
                exp_addr++;
                en_cnt++;
            end
            if (we_r !== 1'b0 || we_l !== 1'b0) we_ok = 1'b0;
        end
        check({tag, " valid_latency"}, 40'(cyc), 40'd31);
        check({tag, " en_cycles"}, 40'(en_cnt), 40'd28);
        check({tag, " addr_seq"}, 40'(addr_ok), 40'd1);
        check({tag, " we_low"}, 40'(we_ok), 40'd1);
        check({tag, " valid_lin"}, 40'(valid_l), 40'd1);
        check({tag, " data_relu"}, 40'(data_r), 40'(exp_r));
        check({tag, " data_lin"}, 40'(data_l), 40'(exp_l));
        if (do_handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, " valid_drop"}, 40'(valid_r), 40'd0);
            check({tag, " busy_drop"}, 40'(busy_r), 40'd0);
            check({tag, " valid_drop_lin"}, 40'(valid_l), 40'd0);
        end
    endtask

    initial begin
        int guard;
        fill(16'h0000, 16'h0000);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", 40'(busy_r), 40'd0);
        check("rst en", 40'(en_r), 40'd0);
        check("rst addr", 40'(addr_r), 40'd0);
        check("rst valid", 40'(valid_r), 40'd0);
        check("rst data", 40'(data_r), 40'd0);
        check("rst we", 40'(we_r), 40'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", 40'(busy_r), 40'd0);

        // 1.0 * 1.0 summed 28 times
        fill(16'h0100, 16'h0100);
        run_eval("t1_ones", 16'h0000, 16'h1C00, 16'h1C00, 1'b1);

        // -1.0 * 0.5 summed 28 times = -14.0
        fill(16'hFF00, 16'h0080);
        run_eval("t2_neg", 16'h0000, 16'h0000, 16'hF200, 1'b1);

        // Positive and negative saturation
        fill(16'h7FFF, 16'h7FFF);
        run_eval("t3_satpos", 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1);
        fill(16'h7FFF, 16'h8001);
        run_eval("t3_satneg", 16'h0000, 16'h0000, 16'h8000, 1'b1);

        // Negative bias: 28.0 - 16.0 = 12.0
        fill(16'h0100, 16'h0100);
        run_eval("t_bias_neg", 16'hF000, 16'h0C00, 16'h0C00, 1'b1);

        // Floor on the rescale: -28/256 floors to -1 LSB
        fill(16'hFFFF, 16'h0001);
        run_eval("t_floor", 16'h0000, 16'h0000, 16'hFFFF, 1'b1);

        // Address-dependent weights: sum of 0..27 = 378 = 0x017A
        for (int i = 0; i < 32; i++) begin
            w_mem[i] = 16'(i);
            x_mem[i] = 16'h0100;
        end
        run_eval("t_ramp", 16'h0000, 16'h017A, 16'h017A, 1'b1);

        // 4. Bias only, backpressure held with a START pulse inside DONE
        fill(16'h0000, 16'h0000);
        run_eval("t4_bias", 16'h0380, 16'h0380, 16'h0380, 1'b0);
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            @(negedge clk);
            check("t4_hold data", 40'(data_r), 40'h0380);
            check("t4_hold valid", 40'(valid_r), 40'd1);
            check("t4_hold busy", 40'(busy_r), 40'd1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_release valid", 40'(valid_r), 40'd0);
        check("t4_release busy", 40'(busy_r), 40'd0);
        @(negedge clk);
        check("t4_start_ignored busy", 40'(busy_r), 40'd0);
        check("t4_start_ignored en", 40'(en_r), 40'd0);

        // 5. Asynchronous abort mid-sweep, then a clean rerun
        fill(16'h0100, 16'h0100);
        @(negedge clk);
        start = 1'b1;
        bias = 16'h0000;
        guard = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            guard++;
        end while (!(en_r === 1'b1 && addr_r === 5'd10) && guard < 50);
        check("t5_reach addr", 40'(addr_r), 40'd10);
        rst_n = 1'b0;
        #1;
        check("t5_abort en", 40'(en_r), 40'd0);
        check("t5_abort addr", 40'(addr_r), 40'd0);
        check("t5_abort valid", 40'(valid_r), 40'd0);
        check("t5_abort busy", 40'(busy_r), 40'd0);
        check("t5_abort en_lin", 40'(en_l), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_eval("t5_rerun", 16'h0000, 16'h1C00, 16'h1C00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
